// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: shift-add MUL, restoring signed DIV, one iteration per cycle.
// Define MUL_DIV_UNIT_DIV_EN to build in the DIV datapath (alu_op 4'd8); otherwise 4'd8 is unsupported.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             illegal
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [3:0] OP_MUL = 4'd7;
  localparam logic [3:0] OP_DIV = 4'd8;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_d;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc, xr, yr;
  logic [WIDTH-1:0] acc_nx, xr_nx, yr_nx, fin;
  logic             supported, last;

`ifdef MUL_DIV_UNIT_DIV_EN
  // is_div is the latched opcode; neg/dz drive the post-loop sign and divide-by-zero fixups
  logic             is_div, neg, dz;
  logic [WIDTH:0]   rem_sh, rem_diff;
  logic             rem_ge;
  assign supported = (alu_op == OP_MUL) || (alu_op == OP_DIV);
  assign rem_sh    = {acc, xr[WIDTH-1]};
  assign rem_diff  = rem_sh - {1'b0, yr};
  assign rem_ge    = (rem_sh >= {1'b0, yr});
`else
  assign supported = (alu_op == OP_MUL);
`endif

  assign last = (cnt == CW'(WIDTH - 1));
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = supported ? CALC : DONE;
      CALC:    if (last) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // One iteration: MUL accumulates shifted multiplicand; DIV shifts a dividend bit into the remainder
  always_comb begin
    acc_nx = yr[0] ? acc + xr : acc;
    xr_nx  = xr << 1;
    yr_nx  = yr >> 1;
    fin    = acc_nx;
`ifdef MUL_DIV_UNIT_DIV_EN
    if (is_div) begin
      acc_nx = rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      xr_nx  = {xr[WIDTH-2:0], rem_ge};
      yr_nx  = yr;
      fin    = dz ? '1 : (neg ? -xr_nx : xr_nx);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      acc     <= '0;
      xr      <= '0;
      yr      <= '0;
      result  <= '0;
      illegal <= 1'b0;
`ifdef MUL_DIV_UNIT_DIV_EN
      is_div  <= 1'b0;
      neg     <= 1'b0;
      dz      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          if (supported) begin
            cnt <= '0;
            acc <= '0;
            xr  <= op_a;
            yr  <= op_b;
`ifdef MUL_DIV_UNIT_DIV_EN
            is_div <= (alu_op == OP_DIV);
            neg    <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
            dz     <= (op_b == '0);
            if (alu_op == OP_DIV) begin
              xr <= op_a[WIDTH-1] ? -op_a : op_a;
              yr <= op_b[WIDTH-1] ? -op_b : op_b;
            end
`endif
          end else begin
            result  <= '0;
            illegal <= 1'b1;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          acc <= acc_nx;
          xr  <= xr_nx;
          yr  <= yr_nx;
          if (last) begin
            result  <= fin;
            illegal <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: arithmetic reference model checked every cycle plus literal pins.
module tb_mul_div_unit;
  localparam int W = 32;

  logic         clk, rst_n, start;
  logic [3:0]   alu_op;
  logic [W-1:0] op_a, op_b;
  logic         busy, done, illegal;
  logic [W-1:0] result;

  int n_vec = 0;
  int n_bad = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_op(alu_op),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
    .result(result), .illegal(illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit model_ok(input logic [3:0] op);
`ifdef MUL_DIV_UNIT_DIV_EN
    return (op == 4'd7) || (op == 4'd8);
`else
    return (op == 4'd7);
`endif
  endfunction

  // Plain arithmetic reference: RV32M-style MUL low half and signed DIV
  function automatic logic [W-1:0] model_res(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    if (!model_ok(op)) return '0;
    if (op == 4'd7) begin
      p = a * b;
      return p[W-1:0];
    end
    if (b == '0) return '1;
    if (a == {1'b1, {(W-1){1'b0}}} && b == '1) return a;
    return $signed(a) / $signed(b);
  endfunction

  // Model: busy window of (latency) cycles, done in its last cycle, outputs update as it opens
  logic         m_busy;
  int           m_left;
  logic [W-1:0] m_res, m_pend;
  logic         m_ill;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_left <= 0; m_res <= '0; m_pend <= '0; m_ill <= 1'b0;
    end else if (m_busy) begin
      if (m_left == 0) m_busy <= 1'b0;
      else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin m_res <= m_pend; m_ill <= 1'b0; end
      end
    end else if (start) begin
      m_busy <= 1'b1;
      if (model_ok(alu_op)) begin
        m_left <= W;
        m_pend <= model_res(alu_op, op_a, op_b);
      end else begin
        m_left <= 0; m_res <= '0; m_ill <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    n_vec++;
    if (busy !== m_busy || done !== (m_busy && m_left == 0) || result !== m_res || illegal !== m_ill) begin
      n_bad++;
      $display("FAIL cycle-compare t=%0t: got busy=%b done=%b result=%h illegal=%b, need busy=%b done=%b result=%h illegal=%b",
               $time, busy, done, result, illegal, m_busy, (m_busy && m_left == 0), m_res, m_ill);
    end
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, need %h", name, got, exp);
    end
  endtask

  // Issue one request, scramble inputs after accept, optionally poke start mid-flight
  task automatic run_op(input string name, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] er, input logic ei, input bit poke);
    int k;
    bit seen;
    @(negedge clk);
    start = 1'b1; alu_op = op; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0; alu_op = 4'd2; op_a = $urandom; op_b = $urandom;
    k = 0; seen = 0;
    while (!seen && k < 100) begin
      @(negedge clk);
      k++;
      if (done) seen = 1;
      start = (poke && k == 5);
      if (poke && k == 5) begin alu_op = 4'd7; op_a = 32'd1; op_b = 32'd1; end
    end
    start = 1'b0;
    check({name, " latency"}, k, ei ? 1 : W + 1);
    check({name, " result"}, result, er);
    check({name, " illegal"}, {31'd0, illegal}, {31'd0, ei});
    @(negedge clk);
    check({name, " single done"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; alu_op = 4'd0; op_a = '0; op_b = '0;
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset result", result, 32'd0);
    check("reset illegal", {31'd0, illegal}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("mul 7*-3", 4'd7, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 0);
    run_op("mul 123*456", 4'd7, 32'd123, 32'd456, 32'h0000_DB18, 1'b0, 0);
    run_op("mul -1*-1", 4'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, 0);
    run_op("mul overflow", 4'd7, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 0);
    run_op("unsupported 2", 4'd2, 32'd9, 32'd9, 32'd0, 1'b1, 0);
`ifdef MUL_DIV_UNIT_DIV_EN
    run_op("div -7/2", 4'd8, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 0);
    run_op("div min/-1", 4'd8, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 0);
    run_op("div 5/0", 4'd8, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 0);
    run_op("div -5/0", 4'd8, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1'b0, 0);
    run_op("div 100/7", 4'd8, 32'd100, 32'd7, 32'd14, 1'b0, 0);
    run_op("div -100/-7", 4'd8, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 1'b0, 0);
    run_op("div 7/-100", 4'd8, 32'd7, 32'hFFFF_FF9C, 32'd0, 1'b0, 0);
`else
    run_op("div disabled", 4'd8, 32'd100, 32'd7, 32'd0, 1'b1, 0);
`endif
    run_op("mul with poke", 4'd7, 32'd6, 32'd7, 32'd42, 1'b0, 1);

    // Abort a MUL at cycle 10 with reset
    @(negedge clk);
    start = 1'b1; alu_op = 4'd7; op_a = 32'd3; op_b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort result", result, 32'd0);
    check("abort illegal", {31'd0, illegal}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("no done after abort", {31'd0, done}, 32'd0);
    end
    run_op("mul 6*6", 4'd7, 32'd6, 32'd6, 32'd36, 1'b0, 0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, request strobe, sampled only in IDLE.
REQ-005 SHALL have port alu_op, input, 4, operation code: 4'd7 MUL, 4'd8 DIV, all other codes unsupported.
REQ-006 SHALL have port op_a, input, WIDTH, multiplicand or dividend.
REQ-007 SHALL have port op_b, input, WIDTH, multiplier or divisor.
REQ-008 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-009 SHALL have port done, output, 1, single-cycle pulse marking result valid.
REQ-010 SHALL have port result, output, WIDTH, last completed result, held until the next accepted start.
REQ-011 SHALL have port illegal, output, 1, qualifies done: the completed request was unsupported.

Function
REQ-012 SHALL implement FSM states IDLE, CALC and DONE.
REQ-013 IDLE with start=1 and supported alu_op SHALL latch alu_op, op_a and op_b, clear the iteration counter and enter CALC.
REQ-014 IDLE with start=1 and unsupported alu_op SHALL enter DONE directly, with result=0 and illegal=1.
REQ-015 CALC SHALL perform exactly one iteration per cycle for WIDTH cycles, then enter DONE.
REQ-016 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-017 busy SHALL be 1 in CALC and DONE, and 0 in IDLE.
REQ-018 Supported-op latency: done SHALL be high in the (WIDTH+1)th cycle after the start-accept edge, independent of operand values.
REQ-019 Unsupported-op latency: done SHALL be high in the cycle after the start-accept edge.
REQ-020 start while busy=1 SHALL be ignored, with no queuing and no effect on the operation in flight.
REQ-021 MUL SHALL use iterative shift-add and return the low WIDTH bits of op_a*op_b; the low half is identical for signed and unsigned operands.
REQ-022 DIV SHALL be signed per RV32M, using restoring division on magnitudes followed by sign correction; the quotient truncates toward zero.
REQ-023 DIV by zero SHALL return all ones (-1) for any dividend.
REQ-024 DIV of the most negative value by -1 SHALL return the most negative value, with no trap.
REQ-025 result and illegal SHALL update only on entry to DONE and otherwise hold.
REQ-026 illegal SHALL be 0 for supported ops.
REQ-027 Latched operands SHALL be used throughout, so op_a, op_b and alu_op may change after the accept edge.

Reset
REQ-028 rst_n=0 SHALL immediately force state to IDLE and set busy=0, done=0, result=0, illegal=0, and clear all internal registers.
REQ-029 Reset during CALC or DONE SHALL abort the operation and produce no done pulse after release.
REQ-030 The first start SHALL be accepted at the first rising clk edge after rst_n deasserts.

Configuration
REQ-031 Macro MUL_DIV_UNIT_DIV_EN defined: the DIV datapath SHALL be compiled in and alu_op 4'd8 SHALL be supported.
REQ-032 Macro MUL_DIV_UNIT_DIV_EN undefined: the DIV datapath SHALL be absent, and 4'd8 SHALL be unsupported and handled per REQ-014 and REQ-019.
REQ-033 MUL behaviour SHALL be identical in both configurations.

Verification
REQ-034 MUL: op_a=7, op_b=-3 (0xFFFFFFFD), WIDTH=32 -> done in cycle 33 after accept; result=0xFFFFFFEB (-21); illegal=0.
REQ-035 DIV with the macro defined: op_a=-7, op_b=2 -> result=0xFFFFFFFD (-3); op_a=0x80000000, op_b=0xFFFFFFFF -> result=0x80000000.
REQ-036 DIV by zero with the macro defined: op_a=5, then op_a=-5, each with op_b=0 -> result=0xFFFFFFFF both times, latency 33.
REQ-037 Unsupported and protocol: alu_op=4'd2 -> done+illegal the next cycle, result=0; with the macro undefined, alu_op=4'd8 behaves the same; start pulsed at cycle 5 of a MUL -> ignored, single done, correct result.
REQ-038 Reset: rst_n low at cycle 10 of a MUL -> busy, done, result and illegal are 0 immediately, and no done follows; a new MUL 6*6 afterwards -> result=36.
